axis_stream_scoreboard: RTL

AXIS_STREAM_SCOREBOARD -- requirements
Module: axis_stream_scoreboard

---
 rtl/axis_stream_scoreboard.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/axis_stream_scoreboard.sv
// axis_stream_scoreboard
//   Compares an observed AXI-Stream against a queued reference stream and keeps
//   beat, packet and tag-check statistics.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   clr                    synchronous clear of counters, sticky flags and packet state
//   s_exp_*                reference beats {tlast, tkeep, tdata}, queued in a 2^AW FIFO
//   s_obs_*                observed beats, compared against the FIFO head on handshake
//   s_tag_*                tag-check results, all-zero tdata means pass
//   beat_err_cnt           beats that mismatched (or arrived with nothing queued)
//   pkt_cnt, pkt_err_cnt   packets closed by observed tlast, and those with any bad beat
//   tag_ok_cnt/tag_err_cnt passing / failing tag results
//   err                    sticky: any mismatch, tag error or underflow
//   underflow              sticky: observed beat accepted with the FIFO empty
//
// All statistics counters saturate at 2^32-1.

module axis_stream_scoreboard #(
    parameter int unsigned DW      = 128,
    parameter int unsigned AW      = 4,
    parameter int unsigned TW      = 128,
    parameter int unsigned KEEP_EN = 1,
    parameter int unsigned STRICT  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,

    input  logic              s_exp_tvalid,
    output logic              s_exp_tready,
    input  logic              s_exp_tlast,
    input  logic [DW-1:0]     s_exp_tdata,
    input  logic [DW/8-1:0]   s_exp_tkeep,

    input  logic              s_obs_tvalid,
    output logic              s_obs_tready,
    input  logic              s_obs_tlast,
    input  logic [DW-1:0]     s_obs_tdata,
    input  logic [DW/8-1:0]   s_obs_tkeep,

    input  logic              s_tag_tvalid,
    output logic              s_tag_tready,
    input  logic [TW-1:0]     s_tag_tdata,

    output logic [31:0]       beat_err_cnt,
    output logic [31:0]       pkt_cnt,
    output logic [31:0]       pkt_err_cnt,
    output logic [31:0]       tag_ok_cnt,
    output logic [31:0]       tag_err_cnt,
    output logic              err,
    output logic              underflow
);

    localparam int unsigned KW    = DW / 8;
    localparam int unsigned EW    = DW + KW + 1;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } pkt_state_e;

    // Expected-beat storage; extra pointer bit distinguishes full from empty
    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Held low through reset so neither stream is accepted until it releases
    logic          ports_en;

    pkt_state_e    state;
    logic          pkt_bad;

    logic          empty;
    logic          full;
    logic          push;
    logic          obs_hs;
    logic          pop;
    logic          uflow_ev;
    logic          tag_hs;
    logic          tag_bad;

    logic [EW-1:0] head;
    logic          h_last;
    logic [KW-1:0] h_keep;
    logic [DW-1:0] h_data;
    logic          data_diff;
    logic          beat_bad;
    logic          pkt_bad_now;

    // FIFO status and handshakes
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign s_exp_tready = ports_en && !full;
    assign s_obs_tready = (STRICT != 0) ? ports_en : (ports_en && !empty);
    assign s_tag_tready = 1'b1;

    assign push     = s_exp_tvalid && s_exp_tready;
    assign obs_hs   = s_obs_tvalid && s_obs_tready;
    assign pop      = obs_hs && !empty;
    assign uflow_ev = obs_hs && empty;
    assign tag_hs   = s_tag_tvalid && s_tag_tready;
    assign tag_bad  = (s_tag_tdata != '0);

    // FIFO head (no bypass: a beat written this cycle is visible next cycle)
    assign head   = mem[rd_ptr[AW-1:0]];
    assign h_last = head[EW-1];
    assign h_keep = head[DW +: KW];
    assign h_data = head[DW-1:0];

    // Byte-lane data compare, masked by expected tkeep when KEEP_EN is set
    always_comb begin
        data_diff = 1'b0;
        for (int unsigned i = 0; i < KW; i++) begin
            if (((KEEP_EN == 0) || h_keep[i]) &&
                (h_data[8*i +: 8] != s_obs_tdata[8*i +: 8])) begin
                data_diff = 1'b1;
            end
        end
    end

    // An underflow beat has nothing to compare against and always counts as bad
    assign beat_bad    = uflow_ev || (h_last != s_obs_tlast) ||
                         (h_keep != s_obs_tkeep) || data_diff;
    assign pkt_bad_now = beat_bad || ((state == ST_IN_PKT) && pkt_bad);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {s_exp_tlast, s_exp_tkeep, s_exp_tdata};
        end
    end

    // Pointers, packet FSM, statistics and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            ports_en     <= 1'b0;
            state        <= ST_IDLE;
            pkt_bad      <= 1'b0;
            beat_err_cnt <= '0;
            pkt_cnt      <= '0;
            pkt_err_cnt  <= '0;
            tag_ok_cnt   <= '0;
            tag_err_cnt  <= '0;
            err          <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            ports_en <= 1'b1;

            // FIFO contents survive clr; only rst empties it
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end

            if (clr) begin
                state        <= ST_IDLE;
                pkt_bad      <= 1'b0;
                beat_err_cnt <= '0;
                pkt_cnt      <= '0;
                pkt_err_cnt  <= '0;
                tag_ok_cnt   <= '0;
                tag_err_cnt  <= '0;
                err          <= 1'b0;
                underflow    <= 1'b0;
            end else begin
                if (obs_hs) begin
                    if (beat_bad) begin
                        beat_err_cnt <= sat_inc(beat_err_cnt);
                        err          <= 1'b1;
                    end
                    if (uflow_ev) begin
                        underflow <= 1'b1;
                    end
                    if (s_obs_tlast) begin
                        pkt_cnt <= sat_inc(pkt_cnt);
                        if (pkt_bad_now) begin
                            pkt_err_cnt <= sat_inc(pkt_err_cnt);
                        end
                        state   <= ST_IDLE;
                        pkt_bad <= 1'b0;
                    end else begin
                        state   <= ST_IN_PKT;
                        pkt_bad <= pkt_bad_now;
                    end
                end

                if (tag_hs) begin
                    if (tag_bad) begin
                        tag_err_cnt <= sat_inc(tag_err_cnt);
                        err         <= 1'b1;
                    end else begin
                        tag_ok_cnt <= sat_inc(tag_ok_cnt);
                    end
                end
            end
        end
    end

endmodule
